ddc_slot_serializer: RTL

//  Counterpart to the hclkin /DIV clock divider: moves sample words from the divided-rate world back to full rate.

---
 rtl/ddc_slot_serializer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ddc_slot_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : ddc_slot_serializer
//  Purpose  : Converts one DIV-lane word per slot (DIV hclkin cycles) into
//             one DATA_W sample per hclkin cycle, lane 0 first. Produces a
//             registered slot_ce pulse that stands in for the divided clock.
//             All logic runs on hclkin; no clock-domain crossing.
//  Ports    : hclkin        - sole clock, rising edge
//             resetn        - synchronous active-low reset
//             s_data        - DIV*DATA_W word, lane i at [i*DATA_W +: DATA_W]
//             s_valid/s_ready - word handshake (accept when both high)
//             m_data/m_valid/m_first - registered serialized sample stream
//             slot_ce       - 1-cycle pulse per slot, aligned with lane 0
//             underrun      - sticky flag: a slot began with no word buffered
//             clr_underrun  - clears underrun (a same-edge set wins)
//  Revision : 1.0  initial release
// ============================================================================
module ddc_slot_serializer #(
    parameter int DATA_W = 16,
    parameter int DIV    = 4
) (
    input  logic                  hclkin,
    input  logic                  resetn,
    input  logic [DIV*DATA_W-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    output logic                  m_first,
    output logic                  slot_ce,
    output logic                  underrun,
    input  logic                  clr_underrun
);

    localparam int                c_PH_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(DIV - 1);

    logic [c_PH_W-1:0]     r_ph;
    logic [DIV*DATA_W-1:0] r_buf;
    logic                  r_buf_full;
    logic                  r_armed;
    logic [DIV*DATA_W-1:0] r_shreg;
    logic                  r_active;
    logic [DATA_W-1:0]     r_m_data;
    logic                  r_m_valid;
    logic                  r_m_first;
    logic                  r_slot_ce;
    logic                  r_underrun;

    logic                  w_slot_start;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_lane;

    assign w_slot_start = (r_ph == '0);
    // The buffer always frees up at a slot start (its word moves to the
    // shift register), so a new word can be taken on that same edge.
    assign s_ready      = ~r_buf_full | w_slot_start;
    assign w_accept     = s_valid & s_ready;
    assign w_lane       = r_shreg[r_ph*DATA_W +: DATA_W];

    always_ff @(posedge hclkin) begin
        if (!resetn) begin
            r_ph       <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_armed    <= 1'b0;
            r_shreg    <= '0;
            r_active   <= 1'b0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_first  <= 1'b0;
            r_slot_ce  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_ph      <= (r_ph == c_PH_LAST) ? '0 : r_ph + 1'b1;
            r_slot_ce <= w_slot_start;

            // Output path: a word is only loaded at a slot boundary, so lanes
            // of different words can never interleave.
            if (w_slot_start) begin
                if (r_buf_full) begin
                    r_shreg   <= r_buf;
                    r_m_data  <= r_buf[DATA_W-1:0];
                    r_m_valid <= 1'b1;
                    r_m_first <= 1'b1;
                    r_active  <= 1'b1;
                end else begin
                    r_active  <= 1'b0;
                    r_m_data  <= '0;
                    r_m_valid <= 1'b0;
                    r_m_first <= 1'b0;
                end
            end else begin
                r_m_first <= 1'b0;
                if (r_active) begin
                    r_m_data  <= w_lane;
                    r_m_valid <= 1'b1;
                end else begin
                    r_m_data  <= '0;
                    r_m_valid <= 1'b0;
                end
            end

            // Holding buffer: a same-edge accept keeps it full with the new word.
            if (w_accept) begin
                r_buf      <= s_data;
                r_buf_full <= 1'b1;
                r_armed    <= 1'b1;
            end else if (w_slot_start) begin
                r_buf_full <= 1'b0;
            end

            // Set has priority over clear on the same edge.
            if (w_slot_start && !r_buf_full && r_armed) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign m_first  = r_m_first;
    assign slot_ce  = r_slot_ce;
    assign underrun = r_underrun;

endmodule
`default_nettype wire
